cplx_div_sched: RTL and testbench

//  Scheduler that time-shares one sequential signed multiplier (run/busy handshake) across
//  the six products of a complex division (a+jb)/(c+jd).

---
 rtl/cplx_div_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_cplx_div_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_div_sched.sv
// -----------------------------------------------------------------------------
// cplx_div_sched
//
// Purpose:
//   Time-shares one sequential signed multiplier (run/busy handshake) across the
//   six products of a complex division (a+jb)/(c+jd). It produces the numerator
//   real part (a*c + b*d), the numerator imaginary part (b*c - a*d) and the
//   denominator (c*c + d*d) for the downstream divider stage.
//
// Ports:
//   clock      in   1      master clock
//   reset      in   1      synchronous reset, active high
//   start      in   1      1-cycle pulse: latch a,b,c,d and begin (only when idle)
//   a,b,c,d    in   W      signed operands (dividend a+jb, divisor c+jd)
//   mult_run   out  1      1-cycle pulse to multiplier: start a product
//   mult_x     out  W      multiplier operand X (held while the product runs)
//   mult_y     out  W      multiplier operand Y
//   mult_busy  in   1      multiplier busy; product valid in the cycle it falls
//   mult_prod  in   2W     signed product from the multiplier output register
//   busy       out  1      high from the cycle after start until the done cycle
//   done       out  1      1-cycle pulse: nre/nim/den/div0 valid
//   nre        out  2W+1   a*c + b*d
//   nim        out  2W+1   b*c - a*d
//   den        out  2W+1   c*c + d*d
//   div0       out  1      c==0 && d==0 detected
//
// Optional feature (macro CPLX_DIV0_EN):
//   Defined: a start with c==0 && d==0 skips all products, goes straight to FIN
//   and reports zero results with div0=1.
//   Undefined: no check, div0 is tied to 0 and the full sequence always runs.
// -----------------------------------------------------------------------------
module cplx_div_sched #(
  parameter int W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic                mult_run,
  output logic signed [W-1:0] mult_x,
  output logic signed [W-1:0] mult_y,
  input  logic                mult_busy,
  input  logic signed [2*W-1:0] mult_prod,
  output logic                busy,
  output logic                done,
  output logic signed [2*W:0] nre,
  output logic signed [2*W:0] nim,
  output logic signed [2*W:0] den,
  output logic                div0
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAITB = 3'd2,
    WAITD = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_K = 3'd5;

  state_t state_reg, state_next;
  logic [2:0] k_reg, k_next;

  logic signed [W-1:0] op_a_reg, op_b_reg, op_c_reg, op_d_reg;
  logic signed [W-1:0] op_a_next, op_b_next, op_c_next, op_d_next;

  logic signed [2*W:0] acc_re_reg, acc_im_reg, acc_den_reg;
  logic signed [2*W:0] acc_re_next, acc_im_next, acc_den_next;

  logic signed [2*W:0] prod_ext;
  logic signed [W-1:0] sel_x, sel_y;

  logic                mult_run_reg;
  logic signed [W-1:0] mult_x_reg, mult_y_reg;
  logic                busy_reg, done_reg;
  logic signed [2*W:0] nre_reg, nim_reg, den_reg;

  assign prod_ext = {mult_prod[2*W-1], mult_prod};

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    op_a_next    = op_a_reg;
    op_b_next    = op_b_reg;
    op_c_next    = op_c_reg;
    op_d_next    = op_d_reg;
    acc_re_next  = acc_re_reg;
    acc_im_next  = acc_im_reg;
    acc_den_next = acc_den_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          op_a_next    = a;
          op_b_next    = b;
          op_c_next    = c;
          op_d_next    = d;
          k_next       = 3'd0;
          acc_re_next  = '0;
          acc_im_next  = '0;
          acc_den_next = '0;
          state_next   = ISSUE;
`ifdef CPLX_DIV0_EN
          // Zero divisor: skip the products and report zeros with div0.
          if ((c == '0) && (d == '0)) begin
            state_next = FIN;
          end
`endif
        end
      end

      ISSUE: begin
        state_next = WAITB;
      end

      WAITB: begin
        if (mult_busy) begin
          state_next = WAITD;
        end
      end

      WAITD: begin
        if (!mult_busy) begin
          // Product order: a*c(+re) b*d(+re) b*c(+im) a*d(-im) c*c(+den) d*d(+den)
          case (k_reg)
            3'd0, 3'd1: acc_re_next  = acc_re_reg + prod_ext;
            3'd2:       acc_im_next  = acc_im_reg + prod_ext;
            3'd3:       acc_im_next  = acc_im_reg - prod_ext;
            default:    acc_den_next = acc_den_reg + prod_ext;
          endcase
          if (k_reg == LAST_K) begin
            state_next = FIN;
          end else begin
            k_next     = k_reg + 3'd1;
            state_next = ISSUE;
          end
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand pair for the product about to be issued. Uses the *next* operand
  // and index values so the pair is ready in the first ISSUE cycle.
  always_comb begin
    sel_x = op_d_next;
    sel_y = op_d_next;
    case (k_next)
      3'd0: begin sel_x = op_a_next; sel_y = op_c_next; end
      3'd1: begin sel_x = op_b_next; sel_y = op_d_next; end
      3'd2: begin sel_x = op_b_next; sel_y = op_c_next; end
      3'd3: begin sel_x = op_a_next; sel_y = op_d_next; end
      3'd4: begin sel_x = op_c_next; sel_y = op_c_next; end
      default: begin sel_x = op_d_next; sel_y = op_d_next; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are loaded from the next-state values
  // so they line up with the state they describe (mult_run during ISSUE, done
  // and results during FIN, busy whenever not IDLE).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_c_reg     <= '0;
      op_d_reg     <= '0;
      acc_re_reg   <= '0;
      acc_im_reg   <= '0;
      acc_den_reg  <= '0;
      mult_run_reg <= 1'b0;
      mult_x_reg   <= '0;
      mult_y_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      nre_reg      <= '0;
      nim_reg      <= '0;
      den_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      op_c_reg     <= op_c_next;
      op_d_reg     <= op_d_next;
      acc_re_reg   <= acc_re_next;
      acc_im_reg   <= acc_im_next;
      acc_den_reg  <= acc_den_next;
      mult_run_reg <= (state_next == ISSUE);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_next == FIN);
      if (state_next == ISSUE) begin
        mult_x_reg <= sel_x;
        mult_y_reg <= sel_y;
      end
      if (state_next == FIN) begin
        nre_reg <= acc_re_next;
        nim_reg <= acc_im_next;
        den_reg <= acc_den_next;
      end
    end
  end

`ifdef CPLX_DIV0_EN
  logic div0_reg;

  // FIN entered directly from IDLE only happens on the zero-divisor shortcut.
  always_ff @(posedge clock) begin
    if (reset) begin
      div0_reg <= 1'b0;
    end else if (state_next == FIN) begin
      div0_reg <= (state_reg == IDLE);
    end
  end

  assign div0 = div0_reg;
`else
  assign div0 = 1'b0;
`endif

  assign mult_run = mult_run_reg;
  assign mult_x   = mult_x_reg;
  assign mult_y   = mult_y_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign nre      = nre_reg;
  assign nim      = nim_reg;
  assign den      = den_reg;

endmodule

// File: tb/tb_cplx_div_sched.sv
// -----------------------------------------------------------------------------
// tb_cplx_div_sched
//   Directed bench for cplx_div_sched with a 17-cycle sequential multiplier
//   model. A behavioural model predicts busy/done timing, the operand pairs
//   handed to the multiplier and the final complex-division terms; a single
//   process compares the DUT against it every cycle, plus literal checks.
// -----------------------------------------------------------------------------
module tb_cplx_div_sched;

  localparam int W    = 16;
  localparam int MLAT = 17;
  localparam int FULL_LAT = 1 + 6 * (MLAT + 2);

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic signed [W-1:0] a, b, c, d;
  logic mult_run;
  logic signed [W-1:0] mult_x, mult_y;
  logic mult_busy;
  logic signed [2*W-1:0] mult_prod;
  logic busy, done, div0;
  logic signed [2*W:0] nre, nim, den;

  cplx_div_sched #(.W(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .mult_run(mult_run), .mult_x(mult_x), .mult_y(mult_y),
    .mult_busy(mult_busy), .mult_prod(mult_prod),
    .busy(busy), .done(done), .nre(nre), .nim(nim), .den(den), .div0(div0)
  );

  always #5 clock = ~clock;

  // Sequential multiplier: busy rises the cycle after run, stays high MLAT
  // cycles, product valid in the cycle busy falls.
  int mcnt;
  logic signed [W-1:0] mx, my;
  always @(posedge clock) begin
    if (reset) begin
      mcnt      <= 0;
      mult_busy <= 1'b0;
      mult_prod <= '0;
      mx        <= '0;
      my        <= '0;
    end else if (mult_run) begin
      mcnt      <= MLAT;
      mult_busy <= 1'b1;
      mx        <= mult_x;
      my        <= mult_y;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mult_busy <= 1'b0;
        mult_prod <= mx * my;
      end
    end
  end

  // Model state
  bit     m_active;
  int     m_start, m_done, runs_exp, runs;
  longint e_re, e_im, e_den;
  bit     e_div0;
  longint ex [6];
  longint ey [6];
  int     cyc;
  int     n_checks, n_fail;
  int     s;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic accept_op();
    longint la, lb, lc, ld;
    la = longint'(a); lb = longint'(b); lc = longint'(c); ld = longint'(d);
    m_active = 1'b1;
    m_start  = cyc;
    runs     = 0;
`ifdef CPLX_DIV0_EN
    if (lc == 0 && ld == 0) begin
      m_done   = cyc + 1;
      runs_exp = 0;
      e_re = 0; e_im = 0; e_den = 0;
      e_div0 = 1'b1;
      return;
    end
`endif
    m_done   = cyc + FULL_LAT;
    runs_exp = 6;
    e_re   = la * lc + lb * ld;
    e_im   = lb * lc - la * ld;
    e_den  = lc * lc + ld * ld;
    e_div0 = 1'b0;
    ex = '{la, lb, lb, la, lc, ld};
    ey = '{lc, ld, lc, ld, lc, ld};
  endtask

  task automatic compare();
    bit exp_busy, exp_done;
    exp_busy = m_active && (cyc > m_start) && (cyc <= m_done);
    exp_done = m_active && (cyc == m_done);
    check("busy", longint'(busy), longint'(exp_busy));
    check("done", longint'(done), longint'(exp_done));
    if (mult_run) begin
      if (!exp_busy || runs >= runs_exp) begin
        check("mult_run_unexpected", 1, 0);
      end else begin
        check("mult_x", longint'(mult_x), ex[runs]);
        check("mult_y", longint'(mult_y), ey[runs]);
        runs++;
      end
    end
    if (exp_done) begin
      check("nre", longint'(nre), e_re);
      check("nim", longint'(nim), e_im);
      check("den", longint'(den), e_den);
      check("div0", longint'(div0), longint'(e_div0));
      check("run_count", longint'(runs), longint'(runs_exp));
    end
  endtask

  // One clock: model samples the inputs at the edge, compare on the falling edge.
  task automatic tick();
    bit acc;
    @(posedge clock);
    if (reset) begin
      m_active = 1'b0;
      runs     = 0;
    end else begin
      acc = !m_active && start;
      if (m_active && cyc == m_done) m_active = 1'b0;
      if (acc) accept_op();
    end
    cyc++;
    @(negedge clock);
    compare();
  endtask

  task automatic do_start(input int va, input int vb, input int vc, input int vd);
    a = 16'(va); b = 16'(vb); c = 16'(vc); d = 16'(vd);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; runs = 0; runs_exp = 0;
    m_active = 1'b0; m_start = 0; m_done = 0;
    reset = 1'b1; start = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    @(negedge clock);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_mult_run", longint'(mult_run), 0);
    check("rst_mult_x", longint'(mult_x), 0);
    check("rst_nre", longint'(nre), 0);
    check("rst_div0", longint'(div0), 0);

    // 1: basic operation and latency
    do_start(3, 4, 1, 2);
    wait_done(200);
    check("t1_latency", longint'(cyc - s), FULL_LAT);
    check("t1_nre", longint'(nre), 11);
    check("t1_nim", longint'(nim), -2);
    check("t1_den", longint'(den), 5);

    // 2: extreme operands; start in the done cycle must be ignored
    tick();
    do_start(-32768, -32768, -32768, -32768);
    wait_done(200);
    check("t2_nre", longint'(nre), 64'sd2147483648);
    check("t2_nim", longint'(nim), 0);
    check("t2_den", longint'(den), 64'sd2147483648);
    a = 16'sd1; b = 16'sd1; c = 16'sd1; d = 16'sd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_fin_start_ignored", longint'(busy), 0);

    // 3: second start mid-operation is ignored
    tick();
    do_start(3, 4, 1, 2);
    while (cyc < s + 40) tick();
    a = 16'sd9; b = 16'sd9; c = 16'sd9; d = 16'sd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    check("t3_nre", longint'(nre), 11);
    check("t3_nim", longint'(nim), -2);
    check("t3_den", longint'(den), 5);

    // 4: reset mid-operation, then a fresh operation
    tick();
    do_start(100, -200, -300, 400);
    while (cyc < s + 60) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_busy", longint'(busy), 0);
    check("t4_mult_run", longint'(mult_run), 0);
    check("t4_nre", longint'(nre), 0);
    check("t4_den", longint'(den), 0);
    tick();
    do_start(7, -5, 11, 13);
    wait_done(200);
    check("t4_nre2", longint'(nre), 12);
    check("t4_nim2", longint'(nim), -146);
    check("t4_den2", longint'(den), 290);

    // 5: zero divisor
    tick();
    do_start(5, 7, 0, 0);
    wait_done(200);
`ifdef CPLX_DIV0_EN
    check("t5_latency", longint'(cyc - s), 1);
    check("t5_div0", longint'(div0), 1);
`else
    check("t5_latency", longint'(cyc - s), FULL_LAT);
    check("t5_div0", longint'(div0), 0);
`endif
    check("t5_nre", longint'(nre), 0);
    check("t5_den", longint'(den), 0);

    // 6: back-to-back operations
    tick();
    do_start(32767, -32768, 32767, -32768);
    wait_done(200);
    check("t6_nre_a", longint'(nre), 64'sd2147418113);
    tick();
    do_start(3, 4, 1, 2);
    check("t6_accepted", longint'(busy), 1);
    wait_done(200);
    check("t6_nre_b", longint'(nre), 11);
    repeat (3) tick();
    check("hold_nre", longint'(nre), 11);
    check("hold_nim", longint'(nim), -2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
